// File: rtl/health_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : health_pkg
//  Description : Shared constants for the health-monitor alert path:
//                scheduler state encoding and alarm source indices.
//  Revision    : 1.0  initial release
// ============================================================================
package health_pkg;

    // Alert scheduler state encoding (binary, explicit width)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ANNOUNCE = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    // Alarm source indices; a lower index means a higher priority
    localparam logic [1:0] SRC_FALL = 2'd0;
    localparam logic [1:0] SRC_BPM  = 2'd1;
    localparam logic [1:0] SRC_TEMP = 2'd2;
    localparam logic [1:0] SRC_MED  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/prio_enc4.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc4
//  Description : Combinational 4-bit priority encoder. The lowest set index
//                wins, so the fall alarm always outranks the others.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc4
    import health_pkg::*;
(
    input  logic [3:0] i_vec,
    output logic       o_valid,
    output logic [1:0] o_idx
);

    // Lowest-index set bit selects the source; index is 0 when nothing is set
    always_comb begin
        o_valid = 1'b1;
        o_idx   = SRC_FALL;
        casez (i_vec)
            4'b???1: o_idx = SRC_FALL;
            4'b??10: o_idx = SRC_BPM;
            4'b?100: o_idx = SRC_TEMP;
            4'b1000: o_idx = SRC_MED;
            default: begin
                o_valid = 1'b0;
                o_idx   = SRC_FALL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alert_scheduler
//  Description : Shares one buzzer and alert-code display between the alarm
//                sources. Latches rising edges, serves them by fixed priority,
//                holds the buzzer for HOLD_CYCLES, re-announces unacknowledged
//                alerts after REPEAT_CYCLES and counts re-announcements.
//  Revision    : 1.0  initial release
// ============================================================================
module alert_scheduler
    import health_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 32,
    parameter int CNT_W         = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic             ack,
    output logic             alert_active,
    output logic [1:0]       alert_code,
    output logic             buzzer,
    output logic [N_SRC-1:0] pending,
    output logic [CNT_W-1:0] missed_cnt
);

    localparam int c_MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_TW      = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_TW-1:0] c_HOLD_LD   = c_TW'(HOLD_CYCLES - 1);
    localparam logic [c_TW-1:0] c_REPEAT_LD = c_TW'(REPEAT_CYCLES - 1);

    logic [N_SRC-1:0] r_req_d;
    logic [N_SRC-1:0] r_pending;
    logic [1:0]       r_state;
    logic [c_TW-1:0]  r_timer;
    logic [1:0]       r_alert_code;
    logic             r_buzzer;
    logic             r_alert_active;
    logic [CNT_W-1:0] r_missed_cnt;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr_mask;
    logic             w_ack_live;
    logic             w_cur_valid;
    logic [1:0]       w_cur_idx;

    assign w_rise     = req & ~r_req_d;
    assign w_ack_live = ack && (r_state != ST_IDLE);

    prio_enc4 u_prio_enc4 (
        .i_vec   (r_pending),
        .o_valid (w_cur_valid),
        .o_idx   (w_cur_idx)
    );

    // Acknowledge clears the bit of the source currently being served
    always_comb begin
        w_clr_mask = '0;
        if (w_ack_live) begin
            w_clr_mask[r_alert_code] = 1'b1;
        end
    end

    // Request history; on reset it absorbs levels already high so they are not edges
    always_ff @(posedge clk) begin
        r_req_d <= req;
    end

    // Pending latch: a fresh edge wins over a same-cycle acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_rise;
        end
    end

    // Scheduler FSM with registered annunciator outputs, timer and missed counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_alert_code   <= 2'd0;
            r_buzzer       <= 1'b0;
            r_alert_active <= 1'b0;
            r_missed_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cur_valid) begin
                        r_state        <= ST_ANNOUNCE;
                        r_alert_code   <= w_cur_idx;
                        r_timer        <= c_HOLD_LD;
                        r_buzzer       <= 1'b1;
                        r_alert_active <= 1'b1;
                    end
                end
                ST_ANNOUNCE: begin
                    if (ack) begin
                        r_state        <= ST_IDLE;
                        r_alert_code   <= 2'd0;
                        r_buzzer       <= 1'b0;
                        r_alert_active <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_state  <= ST_WAIT_ACK;
                        r_timer  <= c_REPEAT_LD;
                        r_buzzer <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack first, then preemption by a higher-priority source, then expiry
                    if (ack || (w_cur_valid && (w_cur_idx < r_alert_code))) begin
                        r_state        <= ST_IDLE;
                        r_alert_code   <= 2'd0;
                        r_buzzer       <= 1'b0;
                        r_alert_active <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_state  <= ST_ANNOUNCE;
                        r_timer  <= c_HOLD_LD;
                        r_buzzer <= 1'b1;
                        if (r_missed_cnt != '1) begin
                            r_missed_cnt <= r_missed_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_alert_code   <= 2'd0;
                    r_buzzer       <= 1'b0;
                    r_alert_active <= 1'b0;
                end
            endcase
        end
    end

    assign alert_active = r_alert_active;
    assign alert_code   = r_alert_code;
    assign buzzer       = r_buzzer;
    assign pending      = r_pending;
    assign missed_cnt   = r_missed_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alert_scheduler
//  Description : Directed self-checking bench for alert_scheduler. Inputs are
//                driven and outputs sampled on the falling edge of clk.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alert_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       ack;
    logic       alert_active;
    logic [1:0] alert_code;
    logic       buzzer;
    logic [3:0] pending;
    logic [7:0] missed_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clk = ~clk;

    alert_scheduler #(
        .N_SRC         (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (32),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .ack          (ack),
        .alert_active (alert_active),
        .alert_code   (alert_code),
        .buzzer       (buzzer),
        .pending      (pending),
        .missed_cnt   (missed_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count consecutive cycles buzzer stays at 'lvl', bounded at 200
    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (buzzer === lvl && len < 200) begin
            len++;
            tick(1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0010;
        ack   = 1'b0;
        tick(3);
        reset = 1'b0;

        // Level high through reset is not an edge
        tick(20);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_active",  alert_active, 1'b0);
        chk("rst_buzzer",  buzzer, 1'b0);
        chk("rst_code",    alert_code, 2'd0);
        chk("rst_missed",  missed_cnt, 8'd0);

        // Re-raise req[1]: pending next cycle, buzzer the cycle after
        req = 4'b0000; tick(1);
        req = 4'b0010; tick(1);
        chk("edge_pending", pending, 4'b0010);
        chk("edge_buz_lat", buzzer, 1'b0);
        tick(1);
        chk("edge_buzzer", buzzer, 1'b1);
        chk("edge_code",   alert_code, 2'd1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("ack1_pending", pending, 4'b0000);
        chk("ack1_active",  alert_active, 1'b0);
        req = 4'b0000; tick(2);

        // Single req[3] pulse, no ack: 8 on / 32 off, missed increments
        req = 4'b1000; tick(1);
        req = 4'b0000; tick(1);
        chk("med_code", alert_code, 2'd3);
        run_len(1'b1, cnt);
        chk("med_hold_len", cnt, 8);
        chk("med_wait_active", alert_active, 1'b1);
        run_len(1'b0, cnt);
        chk("med_wait_len", cnt, 32);
        chk("med_missed1", missed_cnt, 8'd1);
        tick(80);
        chk("med_missed3", missed_cnt, 8'd3);
        chk("med_reann_buz", buzzer, 1'b1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("med_ack_pending", pending, 4'b0000);
        tick(1);

        // req[2] and req[0] together: fall first, then temp after one idle cycle
        req = 4'b0101; tick(1);
        req = 4'b0000; tick(1);
        chk("dual_code0", alert_code, 2'd0);
        chk("dual_pending", pending, 4'b0101);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("dual_idle_active", alert_active, 1'b0);
        chk("dual_pending2", pending, 4'b0100);
        tick(1);
        chk("dual_code2", alert_code, 2'd2);
        chk("dual_buz2", buzzer, 1'b1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("dual_clear", pending, 4'b0000);
        tick(1);

        // Preemption of source 3 in WAIT_ACK by source 0
        req = 4'b1000; tick(1);
        req = 4'b0000; tick(1);
        tick(8);
        chk("pre_wait_buz", buzzer, 1'b0);
        chk("pre_wait_act", alert_active, 1'b1);
        chk("pre_wait_code", alert_code, 2'd3);
        req = 4'b0001; tick(1);
        req = 4'b0000; tick(1);
        chk("pre_idle_act", alert_active, 1'b0);
        chk("pre_pending", pending, 4'b1001);
        tick(1);
        chk("pre_code0", alert_code, 2'd0);
        chk("pre_buz0", buzzer, 1'b1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("pre_pending3", pending, 4'b1000);
        tick(1);
        chk("pre_code3", alert_code, 2'd3);
        chk("pre_missed", missed_cnt, 8'd3);

        // Ack on the WAIT_ACK timer-expiry cycle: ack wins, no increment
        tick(8 + 31);
        chk("exp_wait_act", alert_active, 1'b1);
        chk("exp_wait_buz", buzzer, 1'b0);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("exp_ack_act", alert_active, 1'b0);
        chk("exp_ack_missed", missed_cnt, 8'd3);
        chk("exp_ack_pending", pending, 4'b0000);
        tick(1);

        // Saturate missed_cnt: 252 more re-announcements reach 255
        req = 4'b0100; tick(1);
        req = 4'b0000; tick(1);
        tick(252 * 40);
        chk("sat_255", missed_cnt, 8'd255);
        tick(40);
        chk("sat_hold", missed_cnt, 8'd255);
        chk("sat_buz", buzzer, 1'b1);

        // Reset mid-ANNOUNCE clears everything next cycle
        tick(3);
        reset = 1'b1; tick(1);
        chk("mid_rst_active", alert_active, 1'b0);
        chk("mid_rst_buzzer", buzzer, 1'b0);
        chk("mid_rst_code", alert_code, 2'd0);
        chk("mid_rst_pending", pending, 4'b0000);
        chk("mid_rst_missed", missed_cnt, 8'd0);
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
